// File: rtl/opnd_stage_if.sv
// rtl/opnd_stage_if.sv - decode-to-stage and stage-to-execute handshake bundle for opnd_stage
interface opnd_stage_if;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_ra_idx;
    logic [3:0]  dec_rb_idx;
    logic [3:0]  dec_rm_idx;
    logic        dec_ren_a;
    logic        dec_ren_b;
    logic        dec_ren_m;
    logic [31:0] dec_imm;
    logic        dec_use_imm;
    logic [3:0]  dec_wr_idx;
    logic        dec_wen;
    logic [1:0]  dec_wr_scope;

    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_opa;
    logic [31:0] ex_opb;
    logic [31:0] ex_opm;
    logic [3:0]  ex_wr_idx;
    logic        ex_wen;
    logic [1:0]  ex_wr_scope;

    modport master (
        output dec_valid, dec_ra_idx, dec_rb_idx, dec_rm_idx,
               dec_ren_a, dec_ren_b, dec_ren_m, dec_imm, dec_use_imm,
               dec_wr_idx, dec_wen, dec_wr_scope,
        input  dec_ready,
        input  ex_valid, ex_opa, ex_opb, ex_opm, ex_wr_idx, ex_wen, ex_wr_scope,
        output ex_ready
    );

    modport slave (
        input  dec_valid, dec_ra_idx, dec_rb_idx, dec_rm_idx,
               dec_ren_a, dec_ren_b, dec_ren_m, dec_imm, dec_use_imm,
               dec_wr_idx, dec_wen, dec_wr_scope,
        output dec_ready,
        output ex_valid, ex_opa, ex_opb, ex_opm, ex_wr_idx, ex_wen, ex_wr_scope,
        input  ex_ready
    );
endinterface

// File: rtl/opnd_stage.sv
// rtl/opnd_stage.sv - operand stage: regfile reads, writeback bypass, 16-entry scoreboard, execute register
// Optional feature macro: OPND_FWD_EN enables the same-cycle writeback forward path.
module opnd_stage (
    input  logic              clk,
    input  logic              rst,
    opnd_stage_if.slave       bus,
    output logic [3:0]        ra_index_o,
    output logic [3:0]        rb_index_o,
    output logic [3:0]        rm_index_o,
    output logic              ren_a_o,
    output logic              ren_b_o,
    output logic              ren_m_o,
    input  logic [31:0]       rvalue_a_i,
    input  logic [31:0]       rvalue_b_i,
    input  logic [31:0]       rvalue_m_i,
    input  logic              wb_wen_i,
    input  logic [3:0]        wb_idx_i,
    input  logic [31:0]       wb_data_i,
    input  logic [1:0]        wb_scope_i
);

`ifdef OPND_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic [15:0] pend;
    logic [15:0] pend_next;

    logic        ex_valid_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [31:0] opm_q;
    logic [3:0]  wr_idx_q;
    logic        wen_q;
    logic [1:0]  wr_scope_q;

    logic src_a;
    logic src_b;
    logic src_m;
    logic hit_a;
    logic hit_b;
    logic hit_m;
    logic raw_a;
    logic raw_b;
    logic raw_m;
    logic waw;
    logic hazard;
    logic ready;
    logic issue;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_m;

    // Scoped writeback overlaid on the stale register-file value, half by half.
    function automatic logic [31:0] merge_wb(
        input logic [31:0] rv,
        input logic [31:0] wb,
        input logic [1:0]  scope
    );
        logic [15:0] lo;
        logic [15:0] hi;
        lo = scope[0] ? wb[15:0] : rv[15:0];
        case (scope)
            2'b10:   hi = wb[15:0];
            2'b11:   hi = wb[31:16];
            default: hi = rv[31:16];
        endcase
        return {hi, lo};
    endfunction

    assign ra_index_o = bus.dec_ra_idx;
    assign rb_index_o = bus.dec_rb_idx;
    assign rm_index_o = bus.dec_rm_idx;
    assign ren_a_o    = bus.dec_valid & bus.dec_ren_a & ~rst;
    assign ren_b_o    = bus.dec_valid & bus.dec_ren_b & ~rst;
    assign ren_m_o    = bus.dec_valid & bus.dec_ren_m & ~rst;

    assign src_a = bus.dec_ren_a;
    assign src_b = bus.dec_ren_b & ~bus.dec_use_imm;
    assign src_m = bus.dec_ren_m;

    assign hit_a = FWD & src_a & wb_wen_i & (wb_idx_i == bus.dec_ra_idx);
    assign hit_b = FWD & src_b & wb_wen_i & (wb_idx_i == bus.dec_rb_idx);
    assign hit_m = FWD & src_m & wb_wen_i & (wb_idx_i == bus.dec_rm_idx);

    // Without forwarding a pending source stalls even on its writeback cycle.
    assign raw_a = src_a & pend[bus.dec_ra_idx] & ~hit_a;
    assign raw_b = src_b & pend[bus.dec_rb_idx] & ~hit_b;
    assign raw_m = src_m & pend[bus.dec_rm_idx] & ~hit_m;
    assign waw   = bus.dec_wen & pend[bus.dec_wr_idx]
                 & ~(wb_wen_i & (wb_idx_i == bus.dec_wr_idx));

    assign hazard = raw_a | raw_b | raw_m | waw;
    assign ready  = ~rst & (~ex_valid_q | bus.ex_ready) & ~hazard;
    assign issue  = bus.dec_valid & ready;

    assign bus.dec_ready = ready;

    always_comb begin
        op_a = 32'h0;
        op_b = 32'h0;
        op_m = 32'h0;
        if (src_a)
            op_a = hit_a ? merge_wb(rvalue_a_i, wb_data_i, wb_scope_i) : rvalue_a_i;
        if (bus.dec_use_imm)
            op_b = bus.dec_imm;
        else if (src_b)
            op_b = hit_b ? merge_wb(rvalue_b_i, wb_data_i, wb_scope_i) : rvalue_b_i;
        if (src_m)
            op_m = hit_m ? merge_wb(rvalue_m_i, wb_data_i, wb_scope_i) : rvalue_m_i;
    end

    // Set after clear so a new writer claims the register the retiring one frees.
    always_comb begin
        pend_next = pend;
        if (wb_wen_i)
            pend_next[wb_idx_i] = 1'b0;
        if (issue && bus.dec_wen)
            pend_next[bus.dec_wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= 16'h0;
            ex_valid_q <= 1'b0;
            opa_q      <= 32'h0;
            opb_q      <= 32'h0;
            opm_q      <= 32'h0;
            wr_idx_q   <= 4'h0;
            wen_q      <= 1'b0;
            wr_scope_q <= 2'b00;
        end else begin
            pend <= pend_next;
            if (issue) begin
                ex_valid_q <= 1'b1;
                opa_q      <= op_a;
                opb_q      <= op_b;
                opm_q      <= op_m;
                wr_idx_q   <= bus.dec_wr_idx;
                wen_q      <= bus.dec_wen;
                wr_scope_q <= bus.dec_wr_scope;
            end else if (bus.ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_opa      = opa_q;
    assign bus.ex_opb      = opb_q;
    assign bus.ex_opm      = opm_q;
    assign bus.ex_wr_idx   = wr_idx_q;
    assign bus.ex_wen      = wen_q;
    assign bus.ex_wr_scope = wr_scope_q;

endmodule
